// File: rtl/bioee_clkratio_meter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : bioee_clkratio_meter                                       |
// | Description : Measures an asynchronous divided clock (sigin) in units of |
// |               the system clock (clkin). Reports the period and high time |
// |               of each sigin cycle, raises a lock flag once the period    |
// |               has held within +/-1 for LOCK_COUNT captures, and flags a  |
// |               stopped input through a sticky timeout.                    |
// |                                                                          |
// | Parameters  : CNT_W       width of the period / high-time counters       |
// |               LOCK_COUNT  consecutive in-tolerance captures for lock     |
// |                           (1..15)                                        |
// |                                                                          |
// | Ports       : clkin             in   system clock, rising edge           |
// |               reset_n           in   asynchronous active-low reset       |
// |               enable            in   measurement enable (clkin domain)   |
// |               sigin             in   clock under measurement (async)     |
// |               expected_divider  in   expected period (compare build)     |
// |               measured_divider  out  last captured period                |
// |               high_count        out  last captured high time             |
// |               meas_valid        out  1-cycle pulse on each capture       |
// |               locked            out  period stable within +/-1           |
// |               timeout           out  sticky: counter saturated           |
// |               mismatch          out  capture differs from expected       |
// |                                      by more than 1 (compare build)      |
// |                                                                          |
// | Build macro : CLKMETER_COMPARE_EN adds expected_divider / mismatch and   |
// |               the compare logic. Undefined: neither port exists.         |
// |                                                                          |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module bioee_clkratio_meter #(
  parameter int CNT_W      = 16,
  parameter int LOCK_COUNT = 4
) (
  input  logic             clkin,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             sigin,
`ifdef CLKMETER_COMPARE_EN
  input  logic [CNT_W-1:0] expected_divider,
  output logic             mismatch,
`endif
  output logic [CNT_W-1:0] measured_divider,
  output logic [CNT_W-1:0] high_count,
  output logic             meas_valid,
  output logic             locked,
  output logic             timeout
);

  // ------------------------------------------------------------------------
  // Constants
  // ------------------------------------------------------------------------
  localparam logic [CNT_W-1:0] c_cnt_max  = {CNT_W{1'b1}};
  // Value one below saturation: the increment out of this value is the
  // saturation event, so a rise seen here still wins and is captured.
  localparam logic [CNT_W-1:0] c_cnt_near = {{(CNT_W-1){1'b1}}, 1'b0};
  localparam logic [CNT_W-1:0] c_cnt_one  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [3:0]       c_lock_max = 4'(LOCK_COUNT);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_MEASURE = 2'd2
  } state_t;

  // ------------------------------------------------------------------------
  // Declarations
  // ------------------------------------------------------------------------
  logic             r_sync1;
  logic             r_sync2;
  logic             r_hist;
  logic             w_rise;
  logic             w_fall;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_clear;     // IDLE behaviour: clear counter/lock/flags
  logic             w_load;      // restart counter at 1
  logic             w_capture;   // rise in MEASURE: latch period
  logic             w_hi_cap;    // fall in MEASURE: latch high time
  logic             w_sat_evt;   // counter reaches all-ones this edge
  logic             w_sat_drop;  // saturation while measuring: lose lock

  logic [CNT_W-1:0] r_cnt;
  logic             w_near_sat;

  logic [CNT_W-1:0] r_meas;
  logic [CNT_W-1:0] r_high;
  logic             r_valid;
  logic             r_timeout;

  logic [CNT_W-1:0] w_diff;
  logic             w_in_tol;
  logic [3:0]       r_lock_cnt;
  logic [3:0]       w_lock_nxt;
  logic             r_locked;
  logic             w_locked_nxt;

  // ------------------------------------------------------------------------
  // Input synchronizer and edge detection. Free-running so that the history
  // flop already reflects the settled input level when measurement starts.
  // ------------------------------------------------------------------------
  always_ff @(posedge clkin or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_hist  <= 1'b0;
    end else begin
      r_sync1 <= sigin;
      r_sync2 <= r_sync1;
      r_hist  <= r_sync2;
    end
  end

  assign w_rise = r_sync2 & ~r_hist;
  assign w_fall = ~r_sync2 & r_hist;

  assign w_near_sat = (r_cnt == c_cnt_near);

  // ------------------------------------------------------------------------
  // Control FSM: state register
  // ------------------------------------------------------------------------
  always_ff @(posedge clkin or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ------------------------------------------------------------------------
  // Control FSM: next state and datapath strobes. Dropping enable overrides
  // every other event; a rise overrides saturation in the same cycle.
  // ------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_clear     = 1'b0;
    w_load      = 1'b0;
    w_capture   = 1'b0;
    w_hi_cap    = 1'b0;
    w_sat_evt   = 1'b0;
    w_sat_drop  = 1'b0;

    if (!enable) begin
      w_state_nxt = ST_IDLE;
      w_clear     = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state_nxt = ST_ARM;
          w_clear     = 1'b1;
        end

        ST_ARM: begin
          // First rise only aligns the counter; there is no full period yet.
          if (w_rise) begin
            w_load      = 1'b1;
            w_state_nxt = ST_MEASURE;
          end else if (w_near_sat) begin
            w_sat_evt = 1'b1;
          end
        end

        ST_MEASURE: begin
          if (w_rise) begin
            w_load    = 1'b1;
            w_capture = 1'b1;
          end else begin
            w_hi_cap = w_fall;
            if (w_near_sat) begin
              w_sat_evt   = 1'b1;
              w_sat_drop  = 1'b1;
              w_state_nxt = ST_ARM;
            end
          end
        end

        default: begin
          w_state_nxt = ST_IDLE;
          w_clear     = 1'b1;
        end
      endcase
    end
  end

  // ------------------------------------------------------------------------
  // Period counter: restarts at 1 on each rise, saturates at all-ones.
  // ------------------------------------------------------------------------
  always_ff @(posedge clkin or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (w_clear) begin
      r_cnt <= '0;
    end else if (w_load) begin
      r_cnt <= c_cnt_one;
    end else if (r_cnt != c_cnt_max) begin
      r_cnt <= r_cnt + c_cnt_one;
    end
  end

  // ------------------------------------------------------------------------
  // Capture registers and sticky timeout. Captured values survive IDLE so
  // the last reading stays visible after measurement is disabled.
  // ------------------------------------------------------------------------
  always_ff @(posedge clkin or negedge reset_n) begin
    if (!reset_n) begin
      r_meas    <= '0;
      r_high    <= '0;
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_valid <= w_capture;
      if (w_capture) begin
        r_meas <= r_cnt;
      end
      if (w_hi_cap) begin
        r_high <= r_cnt;
      end
      if (w_clear || w_capture) begin
        r_timeout <= 1'b0;
      end else if (w_sat_evt) begin
        r_timeout <= 1'b1;
      end
    end
  end

  // ------------------------------------------------------------------------
  // Lock tracking. The tolerance test compares the new period against the
  // previous capture, still held in r_meas during the capture cycle. A lock
  // count of zero marks the first capture after arming, which is accepted
  // without a delta check.
  // ------------------------------------------------------------------------
  assign w_diff   = (r_cnt >= r_meas) ? (r_cnt - r_meas) : (r_meas - r_cnt);
  assign w_in_tol = (w_diff <= c_cnt_one);

  always_comb begin
    w_lock_nxt   = r_lock_cnt;
    w_locked_nxt = r_locked;
    if (w_clear || w_sat_drop) begin
      w_lock_nxt   = 4'd0;
      w_locked_nxt = 1'b0;
    end else if (w_capture) begin
      if (r_lock_cnt == 4'd0) begin
        w_lock_nxt   = 4'd1;
        w_locked_nxt = (c_lock_max == 4'd1);
      end else if (w_in_tol) begin
        w_lock_nxt   = (r_lock_cnt >= c_lock_max) ? c_lock_max : (r_lock_cnt + 4'd1);
        w_locked_nxt = (w_lock_nxt == c_lock_max);
      end else begin
        w_lock_nxt   = 4'd1;
        w_locked_nxt = 1'b0;
      end
    end
  end

  always_ff @(posedge clkin or negedge reset_n) begin
    if (!reset_n) begin
      r_lock_cnt <= 4'd0;
      r_locked   <= 1'b0;
    end else begin
      r_lock_cnt <= w_lock_nxt;
      r_locked   <= w_locked_nxt;
    end
  end

`ifdef CLKMETER_COMPARE_EN
  // ------------------------------------------------------------------------
  // Optional comparison against the programmed divider.
  // ------------------------------------------------------------------------
  logic [CNT_W-1:0] w_cmp_diff;
  logic             r_mismatch;

  assign w_cmp_diff = (r_cnt >= expected_divider) ? (r_cnt - expected_divider)
                                                  : (expected_divider - r_cnt);

  always_ff @(posedge clkin or negedge reset_n) begin
    if (!reset_n) begin
      r_mismatch <= 1'b0;
    end else if (w_clear) begin
      r_mismatch <= 1'b0;
    end else if (w_capture) begin
      r_mismatch <= (w_cmp_diff > c_cnt_one);
    end else if (w_sat_evt) begin
      r_mismatch <= 1'b1;
    end
  end

  assign mismatch = r_mismatch;
`endif

  // ------------------------------------------------------------------------
  // Outputs
  // ------------------------------------------------------------------------
  assign measured_divider = r_meas;
  assign high_count       = r_high;
  assign meas_valid       = r_valid;
  assign locked           = r_locked;
  assign timeout          = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_bioee_clkratio_meter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_bioee_clkratio_meter                                    |
// | Description : Self-checking bench for bioee_clkratio_meter. sigin is     |
// |               driven on falling clkin edges as whole periods; expected   |
// |               captures and lock state are derived from the list of       |
// |               driven periods.                                            |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_bioee_clkratio_meter;

  localparam int W    = 10;
  localparam int L    = 4;
  localparam int MAXC = (1 << W) - 1;

  logic         clkin   = 1'b0;
  logic         reset_n = 1'b0;
  logic         enable  = 1'b0;
  logic         sigin   = 1'b0;
  logic [W-1:0] measured_divider;
  logic [W-1:0] high_count;
  logic         meas_valid;
  logic         locked;
  logic         timeout;
  logic         mm;

`ifdef CLKMETER_COMPARE_EN
  logic [W-1:0] expected_divider = W'(16);
  logic         mismatch;
  assign mm = mismatch;
`else
  assign mm = 1'b0;
`endif

  bioee_clkratio_meter #(
    .CNT_W      (W),
    .LOCK_COUNT (L)
  ) dut (
    .clkin            (clkin),
    .reset_n          (reset_n),
    .enable           (enable),
    .sigin            (sigin),
`ifdef CLKMETER_COMPARE_EN
    .expected_divider (expected_divider),
    .mismatch         (mismatch),
`endif
    .measured_divider (measured_divider),
    .high_count       (high_count),
    .meas_valid       (meas_valid),
    .locked           (locked),
    .timeout          (timeout)
  );

  always #5 clkin = ~clkin;

  int cyc = 0;
  always @(posedge clkin) cyc = cyc + 1;

  // Record of every meas_valid pulse, sampled mid-cycle.
  typedef struct {
    int md;
    int hc;
    bit lk;
    bit to;
    bit mm;
    int cy;
  } ev_t;
  ev_t evq[$];

  always @(negedge clkin) begin
    ev_t e;
    if (meas_valid === 1'b1) begin
      e.md = int'(measured_divider);
      e.hc = int'(high_count);
      e.lk = locked;
      e.to = timeout;
      e.mm = mm;
      e.cy = cyc;
      evq.push_back(e);
    end
  end

  int total = 0;
  int bad   = 0;
  int g_per[$];
  int g_hi[$];

  // Reference: capture j is locked when at least L captures exist and the
  // last L-1 period-to-period deltas are all within +/-1.
  function automatic bit exp_lock(input int j);
    int d;
    if (j < L - 1) return 1'b0;
    for (int k = j - L + 2; k <= j; k++) begin
      d = g_per[k] - g_per[k-1];
      if (d > 1 || d < -1) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic void push_per(input int p, input int h, input int n);
    for (int i = 0; i < n; i++) begin
      g_per.push_back(p);
      g_hi.push_back(h);
    end
  endfunction

  // Drives each listed period (rise, hi cycles high, rest low), then one
  // closing rise so the last listed period gets captured, then idles low.
  task automatic drive_wave();
    foreach (g_per[i]) begin
      @(negedge clkin) sigin = 1'b1;
      repeat (g_hi[i]) @(negedge clkin);
      sigin = 1'b0;
      repeat (g_per[i] - g_hi[i] - 1) @(negedge clkin);
    end
    @(negedge clkin) sigin = 1'b1;
    repeat (3) @(negedge clkin);
    sigin = 1'b0;
    repeat (8) @(negedge clkin);
  endtask

  task automatic start_session();
    @(negedge clkin);
    enable = 1'b0;
    sigin  = 1'b0;
    repeat (3) @(negedge clkin);
    enable = 1'b1;
    repeat (3) @(negedge clkin);
    evq.delete();
    g_per.delete();
    g_hi.delete();
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clkin);
    total++;
    if (measured_divider !== '0 || high_count !== '0) begin
      bad++;
      $display("FAIL reset_data: got md=%0d hc=%0d want 0 0", measured_divider, high_count);
    end
    total++;
    if ({meas_valid, locked, timeout, mm} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_flags: got mv/lk/to/mm=%b want 0000", {meas_valid, locked, timeout, mm});
    end
    reset_n = 1'b1;
    repeat (2) @(negedge clkin);
  endtask

  task automatic test_basic();
    start_session();
    push_per(16, 8, 6);
    drive_wave();
    total++;
    if (evq.size() != g_per.size()) begin
      bad++;
      $display("FAIL basic_count: got %0d want %0d", evq.size(), g_per.size());
    end
    for (int j = 0; j < evq.size() && j < g_per.size(); j++) begin
      total++;
      if (evq[j].md != g_per[j] || evq[j].hc != g_hi[j] || evq[j].lk != exp_lock(j)) begin
        bad++;
        $display("FAIL basic[%0d]: got md=%0d hc=%0d lk=%0b want md=%0d hc=%0d lk=%0b",
                 j, evq[j].md, evq[j].hc, evq[j].lk, g_per[j], g_hi[j], exp_lock(j));
      end
    end
  endtask

  task automatic test_jitter();
    int pat [4] = '{15, 16, 17, 16};
    start_session();
    for (int i = 0; i < 10; i++) push_per(pat[i % 4], int'($urandom_range(2, 12)), 1);
    drive_wave();
    total++;
    if (evq.size() != g_per.size()) begin
      bad++;
      $display("FAIL jitter_count: got %0d want %0d", evq.size(), g_per.size());
    end
    for (int j = 0; j < evq.size() && j < g_per.size(); j++) begin
      total++;
      if (evq[j].md != g_per[j] || evq[j].hc != g_hi[j] || evq[j].lk != exp_lock(j)) begin
        bad++;
        $display("FAIL jitter[%0d]: got md=%0d hc=%0d lk=%0b want md=%0d hc=%0d lk=%0b",
                 j, evq[j].md, evq[j].hc, evq[j].lk, g_per[j], g_hi[j], exp_lock(j));
      end
    end
  endtask

  task automatic test_switch();
    start_session();
    push_per(16, 8, 6);
    push_per(20, 9, 5);
    drive_wave();
    total++;
    if (evq.size() != g_per.size()) begin
      bad++;
      $display("FAIL switch_count: got %0d want %0d", evq.size(), g_per.size());
    end
    for (int j = 0; j < evq.size() && j < g_per.size(); j++) begin
      total++;
      if (evq[j].md != g_per[j] || evq[j].hc != g_hi[j] || evq[j].lk != exp_lock(j)) begin
        bad++;
        $display("FAIL switch[%0d]: got md=%0d hc=%0d lk=%0b want md=%0d hc=%0d lk=%0b",
                 j, evq[j].md, evq[j].hc, evq[j].lk, g_per[j], g_hi[j], exp_lock(j));
      end
    end
  endtask

  task automatic test_random();
    int p;
    int step;
    for (int r = 0; r < 3; r++) begin
      start_session();
      p = int'($urandom_range(10, 30));
      for (int i = 0; i < 12; i++) begin
        if ($urandom_range(0, 4) == 0) step = int'($urandom_range(2, 5));
        else step = int'($urandom_range(0, 1));
        if ($urandom_range(0, 1) == 1) step = -step;
        p = p + step;
        if (p < 6) p = 6;
        if (p > 60) p = 60;
        push_per(p, int'($urandom_range(2, p - 2)), 1);
      end
      drive_wave();
      total++;
      if (evq.size() != g_per.size()) begin
        bad++;
        $display("FAIL random%0d_count: got %0d want %0d", r, evq.size(), g_per.size());
      end
      for (int j = 0; j < evq.size() && j < g_per.size(); j++) begin
        total++;
        if (evq[j].md != g_per[j] || evq[j].hc != g_hi[j] || evq[j].lk != exp_lock(j)) begin
          bad++;
          $display("FAIL random%0d[%0d]: got md=%0d hc=%0d lk=%0b want md=%0d hc=%0d lk=%0b",
                   r, j, evq[j].md, evq[j].hc, evq[j].lk, g_per[j], g_hi[j], exp_lock(j));
        end
      end
    end
  endtask

  task automatic test_timeout();
    int t0;
    int seen;
    start_session();
    push_per(16, 8, 6);
    drive_wave();
    total++;
    if (evq.size() != 6 || evq[evq.size()-1].lk != 1'b1) begin
      bad++;
      $display("FAIL timeout_prelock: got captures=%0d want 6 locked", evq.size());
    end
    t0   = (evq.size() > 0) ? evq[evq.size()-1].cy : cyc;
    seen = -1;
    for (int k = 0; k < MAXC + 50; k++) begin
      @(negedge clkin);
      if (timeout === 1'b1) begin
        seen = cyc;
        break;
      end
    end
    total++;
    if (seen - t0 != MAXC - 1) begin
      bad++;
      $display("FAIL timeout_time: got %0d cycles want %0d (-1 means never)",
               (seen < 0) ? -1 : seen - t0, MAXC - 1);
    end
    total++;
    if (locked !== 1'b0) begin
      bad++;
      $display("FAIL timeout_lock: got %b want 0", locked);
    end
    // Restart: first rise re-arms, the following captures clear timeout.
    evq.delete();
    g_per.delete();
    g_hi.delete();
    push_per(12, 6, 5);
    drive_wave();
    total++;
    if (evq.size() != 5) begin
      bad++;
      $display("FAIL restart_count: got %0d want 5", evq.size());
    end
    for (int j = 0; j < evq.size() && j < g_per.size(); j++) begin
      total++;
      if (evq[j].md != 12 || evq[j].to != 1'b0 || evq[j].lk != exp_lock(j)) begin
        bad++;
        $display("FAIL restart[%0d]: got md=%0d to=%0b lk=%0b want md=12 to=0 lk=%0b",
                 j, evq[j].md, evq[j].to, evq[j].lk, exp_lock(j));
      end
    end
  endtask

  task automatic test_arm_timeout();
    start_session();
    repeat (MAXC - 20) @(negedge clkin);
    total++;
    if (timeout !== 1'b0) begin
      bad++;
      $display("FAIL arm_early: got timeout=%b want 0", timeout);
    end
    repeat (40) @(negedge clkin);
    total++;
    if (timeout !== 1'b1 || locked !== 1'b0 || evq.size() != 0) begin
      bad++;
      $display("FAIL arm_timeout: got to=%b lk=%b caps=%0d want 1 0 0", timeout, locked, evq.size());
    end
    enable = 1'b0;
    @(negedge clkin);
    total++;
    if (timeout !== 1'b0) begin
      bad++;
      $display("FAIL arm_idle_clear: got timeout=%b want 0", timeout);
    end
  endtask

  task automatic test_reset_mid();
    int n_at;
    bit got;
    start_session();
    push_per(16, 8, 8);
    n_at = 0;
    fork
      drive_wave();
      begin
        got = 1'b0;
        for (int k = 0; k < 400 && !got; k++) begin
          @(negedge clkin);
          if (evq.size() >= 5) got = 1'b1;
        end
        total++;
        if (!got) begin
          bad++;
          $display("FAIL rstmid_wait: got %0d captures want 5", evq.size());
        end
        repeat (5) @(negedge clkin);
        #2;
        reset_n = 1'b0;
        enable  = 1'b0;
        #1;
        total++;
        if ({measured_divider, high_count, meas_valid, locked, timeout, mm} !== '0) begin
          bad++;
          $display("FAIL rstmid_outputs: got md=%0d hc=%0d mv/lk/to/mm=%b want all 0",
                   measured_divider, high_count, {meas_valid, locked, timeout, mm});
        end
        n_at = evq.size();
        @(negedge clkin);
        reset_n = 1'b1;
      end
    join
    total++;
    if (evq.size() != n_at) begin
      bad++;
      $display("FAIL rstmid_glitch: got %0d captures want %0d", evq.size(), n_at);
    end
  endtask

  task automatic test_enable_drop();
    int n_at;
    bit got;
    start_session();
    push_per(16, 8, 8);
    n_at = 0;
    fork
      drive_wave();
      begin
        got = 1'b0;
        for (int k = 0; k < 400 && !got; k++) begin
          @(negedge clkin);
          if (evq.size() >= 5) got = 1'b1;
        end
        repeat (5) @(negedge clkin);
        total++;
        if (!got || locked !== 1'b1) begin
          bad++;
          $display("FAIL endrop_prelock: got lk=%b caps=%0d want 1 5", locked, evq.size());
        end
        enable = 1'b0;
        @(negedge clkin);
        total++;
        if ({locked, timeout, meas_valid, mm} !== 4'b0000 ||
            measured_divider !== W'(16) || high_count !== W'(8)) begin
          bad++;
          $display("FAIL endrop_idle: got lk/to/mv/mm=%b md=%0d hc=%0d want 0000 16 8",
                   {locked, timeout, meas_valid, mm}, measured_divider, high_count);
        end
        n_at = evq.size();
      end
    join
    total++;
    if (evq.size() != n_at) begin
      bad++;
      $display("FAIL endrop_glitch: got %0d captures want %0d", evq.size(), n_at);
    end
  endtask

`ifdef CLKMETER_COMPARE_EN
  task automatic test_compare();
    bit exp_mm [3] = '{1'b0, 1'b1, 1'b0};
    start_session();
    push_per(16, 8, 1);
    push_per(18, 9, 1);
    push_per(17, 8, 1);
    drive_wave();
    total++;
    if (evq.size() != 3) begin
      bad++;
      $display("FAIL compare_count: got %0d want 3", evq.size());
    end
    for (int j = 0; j < evq.size() && j < 3; j++) begin
      total++;
      if (evq[j].mm != exp_mm[j] || evq[j].md != g_per[j]) begin
        bad++;
        $display("FAIL compare[%0d]: got mm=%0b md=%0d want mm=%0b md=%0d",
                 j, evq[j].mm, evq[j].md, exp_mm[j], g_per[j]);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_jitter();
    test_switch();
    test_random();
    test_timeout();
    test_arm_timeout();
    test_reset_mid();
    test_enable_drop();
`ifdef CLKMETER_COMPARE_EN
    test_compare();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
`default_nettype wire
